// File: rtl/pwm_fifo_pkg.sv
// Shared types and constants for the PWM gate-signal FIFO scheduler.
// Holds the FSM encoding, default sizing and the index-width helper.
package pwm_fifo_pkg;

    localparam int N_UNITS_DEF    = 10;
    localparam int FIFO_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_e;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_fifo_sched_burst_cnt.sv
// N_UNITS-cycle burst window with unit index.
// A start on the last window cycle chains a new burst with no gap.
module sched_burst_cnt
    import pwm_fifo_pkg::*;
#(
    parameter int N_UNITS = N_UNITS_DEF,
    parameter int IDX_W   = idx_w(N_UNITS_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             start,
    output logic             active,
    output logic [IDX_W-1:0] idx,
    output logic             last,
    output logic             collision
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNITS - 1);

    logic accept;

    assign last      = active & (idx == LAST_IDX);
    assign collision = start & active & ~last;
    assign accept    = start & (~active | last);

    // Window/index register: clear wins, then restart, then advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            idx    <= '0;
        end else if (clear) begin
            active <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            active <= 1'b1;
            idx    <= '0;
        end else if (last) begin
            active <= 1'b0;
            idx    <= '0;
        end else if (active) begin
            idx    <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/pwm_fifo_sched.sv
// Sequencer for the shared PWM gate FIFO: write/read bursts per step,
// priming hold-off, read-aligned output enable and sticky error flags.
module pwm_fifo_sched
    import pwm_fifo_pkg::*;
#(
    parameter int N_UNITS    = N_UNITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int USEDW_W    = $clog2(FIFO_DEPTH_DEF),
    parameter int IDX_W      = idx_w(N_UNITS_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rst_user,
    input  logic               wr_start,
    input  logic               rd_start,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_wrreq,
    output logic               fifo_rdreq,
    output logic               fifo_sclr,
    output logic [IDX_W-1:0]   wr_idx,
    output logic               out_ena,
    output logic [IDX_W-1:0]   out_idx,
    output logic               primed,
    output logic               ovf_err,
    output logic               udf_err,
    output logic               col_err
);

    if (N_UNITS < 1 || N_UNITS >= FIFO_DEPTH) begin : g_bad_cfg
        $error("pwm_fifo_sched: N_UNITS must be 1..FIFO_DEPTH-1");
    end

    sched_state_e state_q, state_d;

    logic             wr_go, rd_go;
    logic             wr_active, wr_last, wr_col;
    logic             rd_active, rd_last, rd_col;
    logic [IDX_W-1:0] rd_idx;
    logic             wr_accept;
    logic             usedw_ok;

    // Starts are ignored during a flush; reads need a primed FIFO.
    assign wr_go  = wr_start & ~rst_user;
    assign rd_go  = rd_start & ~rst_user & primed;
    assign primed = (state_q == ST_RUN);

    assign wr_accept = wr_go & (~wr_active | wr_last);
    assign usedw_ok  = (fifo_usedw >= USEDW_W'(N_UNITS - 1));

    assign fifo_wrreq = wr_active & ~fifo_full;
    assign fifo_rdreq = rd_active & ~fifo_empty;

    sched_burst_cnt #(
        .N_UNITS (N_UNITS),
        .IDX_W   (IDX_W)
    ) u_wr_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (rst_user),
        .start     (wr_go),
        .active    (wr_active),
        .idx       (wr_idx),
        .last      (wr_last),
        .collision (wr_col)
    );

    sched_burst_cnt #(
        .N_UNITS (N_UNITS),
        .IDX_W   (IDX_W)
    ) u_rd_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (rst_user),
        .start     (rd_go),
        .active    (rd_active),
        .idx       (rd_idx),
        .last      (rd_last),
        .collision (rd_col)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: prime on the first write, run once a full step is in.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_accept) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (wr_last && usedw_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst_user) begin
            state_d = ST_IDLE;
        end
    end

    // FIFO q is valid one cycle after rdreq: align enable and index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_ena <= 1'b0;
            out_idx <= '0;
        end else begin
            out_ena <= fifo_rdreq;
            out_idx <= rd_idx;
        end
    end

    // One-cycle FIFO clear following a soft reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_sclr <= 1'b0;
        end else begin
            fifo_sclr <= rst_user;
        end
    end

    // Sticky error flags, cleared by soft reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
            col_err <= 1'b0;
        end else if (rst_user) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
            col_err <= 1'b0;
        end else begin
            if (wr_active && fifo_full) begin
                ovf_err <= 1'b1;
            end
            if (rd_active && fifo_empty) begin
                udf_err <= 1'b1;
            end
            if (wr_col || rd_col) begin
                col_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_fifo_sched.sv
// Self-checking bench for pwm_fifo_sched with a FIFO fill model and
// an out_idx scoreboard fed at read-start time.
module tb_pwm_fifo_sched;

    localparam int N   = 10;
    localparam int DEP = 16;
    localparam int UW  = 4;
    localparam int IW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_user = 1'b0;
    logic          wr_start = 1'b0;
    logic          rd_start = 1'b0;
    logic          fifo_empty;
    logic          fifo_full;
    logic [UW-1:0] fifo_usedw;
    logic          fifo_wrreq;
    logic          fifo_rdreq;
    logic          fifo_sclr;
    logic [IW-1:0] wr_idx;
    logic          out_ena;
    logic [IW-1:0] out_idx;
    logic          primed;
    logic          ovf_err;
    logic          udf_err;
    logic          col_err;

    logic force_full = 1'b0;
    logic force_empty = 1'b0;
    int   cnt;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_q[$];

    always #5 clk = ~clk;

    pwm_fifo_sched #(
        .N_UNITS    (N),
        .FIFO_DEPTH (DEP),
        .USEDW_W    (UW),
        .IDX_W      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rst_user   (rst_user),
        .wr_start   (wr_start),
        .rd_start   (rd_start),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_usedw (fifo_usedw),
        .fifo_wrreq (fifo_wrreq),
        .fifo_rdreq (fifo_rdreq),
        .fifo_sclr  (fifo_sclr),
        .wr_idx     (wr_idx),
        .out_ena    (out_ena),
        .out_idx    (out_idx),
        .primed     (primed),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err),
        .col_err    (col_err)
    );

    // Fill-level model of the controlled FIFO.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 0;
        end else if (fifo_sclr) begin
            cnt <= 0;
        end else begin
            cnt <= cnt + (fifo_wrreq ? 1 : 0) - (fifo_rdreq ? 1 : 0);
        end
    end

    assign fifo_full  = (cnt >= DEP) | force_full;
    assign fifo_empty = (cnt == 0) | force_empty;
    assign fifo_usedw = UW'(cnt);

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Every out_ena pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_ena) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", 1, 0);
            end else begin
                chk("out_idx", int'(out_idx), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int skip);
        for (int k = 0; k < N; k++) begin
            if (k != skip) exp_q.push_back(k);
        end
    endtask

    // One start cycle, then the N-cycle write window is checked.
    task automatic wr_burst();
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("wr_req", int'(fifo_wrreq), 1);
            chk("wr_idx", int'(wr_idx), i);
            tick();
        end
    endtask

    task automatic rd_burst();
        push_seq(-1);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("rd_req", int'(fifo_rdreq), 1);
            tick();
        end
    endtask

    task automatic drain_check(input string tag);
        repeat (3) tick();
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_outs",
            int'({fifo_wrreq, fifo_rdreq, fifo_sclr, out_ena, primed,
                  ovf_err, udf_err, col_err}), 0);
        chk("rst_idx", int'({wr_idx, out_idx}), 0);
        tick();
        rst = 1'b0;
        tick();

        // Read before priming is ignored without error.
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            chk("unprimed_rd", int'(fifo_rdreq), 0);
            tick();
        end
        chk("unprimed_udf", int'(udf_err), 0);

        // Prime with one step.
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("prime_wr", int'(fifo_wrreq), 1);
            chk("prime_idx", int'(wr_idx), i);
            chk("prime_pre", int'(primed), 0);
            tick();
        end
        @(negedge clk);
        chk("primed", int'(primed), 1);
        chk("wr_done", int'(fifo_wrreq), 0);
        tick();

        // Plain read burst.
        rd_burst();
        drain_check("rd1_drain");
        chk("rd1_level", cnt, 0);

        // Fully overlapped write and read at level N.
        wr_burst();
        push_seq(-1);
        wr_start = 1'b1;
        rd_start = 1'b1;
        tick();
        wr_start = 1'b0;
        rd_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("ovl_wr", int'(fifo_wrreq), 1);
            chk("ovl_rd", int'(fifo_rdreq), 1);
            chk("ovl_level", cnt, N);
            tick();
        end
        drain_check("ovl_drain");
        chk("ovl_errs", int'({ovf_err, udf_err, col_err}), 0);
        rd_burst();
        drain_check("rd2_drain");

        // Full on window cycle 3.
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            force_full = (i == 2);
            @(negedge clk);
            chk("ovf_wr", int'(fifo_wrreq), (i == 2) ? 0 : 1);
            chk("ovf_idx", int'(wr_idx), i);
            tick();
        end
        force_full = 1'b0;
        repeat (2) tick();
        chk("ovf_err", int'(ovf_err), 1);
        chk("ovf_level", cnt, N - 1);

        // Empty on one read cycle: one out_ena pulse goes missing.
        push_seq(4);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            force_empty = (i == 4);
            @(negedge clk);
            chk("udf_rd", int'(fifo_rdreq), (i == 4) ? 0 : 1);
            tick();
        end
        force_empty = 1'b0;
        drain_check("udf_drain");
        chk("udf_err", int'(udf_err), 1);
        chk("ovf_sticky", int'(ovf_err), 1);

        // Back-to-back bursts with no gap, no collision.
        wr_burst();
        push_seq(-1);
        push_seq(-1);
        wr_start = 1'b1;
        rd_start = 1'b1;
        tick();
        for (int i = 0; i < 2 * N; i++) begin
            wr_start = (i == N - 1);
            rd_start = (i == N - 1);
            @(negedge clk);
            chk("b2b_wr", int'(fifo_wrreq), 1);
            chk("b2b_rd", int'(fifo_rdreq), 1);
            chk("b2b_idx", int'(wr_idx), i % N);
            tick();
        end
        wr_start = 1'b0;
        rd_start = 1'b0;
        @(negedge clk);
        chk("b2b_end", int'(fifo_wrreq), 0);
        chk("b2b_col", int'(col_err), 0);
        drain_check("b2b_drain");

        // Restart mid-burst is a collision; length unchanged.
        push_seq(-1);
        wr_start = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr_start = (i == 3);
            @(negedge clk);
            chk("col_wr", int'(fifo_wrreq), 1);
            chk("col_idx", int'(wr_idx), i);
            tick();
        end
        wr_start = 1'b0;
        @(negedge clk);
        chk("col_end", int'(fifo_wrreq), 0);
        chk("col_err", int'(col_err), 1);
        drain_check("col_drain");
        chk("col_level", cnt, N);

        // Soft reset at read index 5.
        for (int k = 0; k < 6; k++) exp_q.push_back(k);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rst_user = (i == 5);
            @(negedge clk);
            chk("ru_rd", int'(fifo_rdreq), 1);
            tick();
        end
        rst_user = 1'b0;
        @(negedge clk);
        chk("ru_sclr", int'(fifo_sclr), 1);
        chk("ru_rd_off", int'(fifo_rdreq), 0);
        chk("ru_primed", int'(primed), 0);
        chk("ru_errs", int'({ovf_err, udf_err, col_err}), 0);
        tick();
        @(negedge clk);
        chk("ru_sclr_1cyc", int'(fifo_sclr), 0);
        chk("ru_level", cnt, 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            chk("ru_rd_ign", int'(fifo_rdreq), 0);
            tick();
        end

        // Re-prime and read once more.
        wr_burst();
        @(negedge clk);
        chk("reprimed", int'(primed), 1);
        tick();
        rd_burst();
        drain_check("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_fifo_sched.md
Name: pwm_fifo_sched

Overview:
Sequencing controller for the shared 1-bit PWM gate-signal FIFO, which is time-multiplexed across N_UNITS wind-turbine converter units per simulation step.
- Turns per-step write-start and read-start pulses into N_UNITS-cycle write and read bursts, each with a unit index.
- Holds off reads until the FIFO has been primed with one full step of data.
- Produces the output-register enable, aligned to FIFO read latency.
- Flags overflow, underflow and burst collisions.

Parameters:
N_UNITS, 10, units per simulation step (burst length); legal range 1..(FIFO_DEPTH-1).
FIFO_DEPTH, 16, depth of the controlled FIFO.
USEDW_W, 4, width of FIFO fill-level input; equals clog2(FIFO_DEPTH).
IDX_W, 4, width of unit index outputs; covers N_UNITS-1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rst_user  in  1  synchronous soft reset/flush
wr_start  in  1  one-cycle pulse: unit-0 data valid on the FIFO data input next cycle
rd_start  in  1  one-cycle pulse: begin reading one step of data
fifo_empty  in  1  FIFO empty flag
fifo_full  in  1  FIFO full flag
fifo_usedw  in  USEDW_W  FIFO fill level
fifo_wrreq  out  1  FIFO write request
fifo_rdreq  out  1  FIFO read request
fifo_sclr  out  1  FIFO synchronous clear
wr_idx  out  IDX_W  unit index of the current write
out_ena  out  1  load enable for the downstream cout/coutf register
out_idx  out  IDX_W  unit index of the data qualified by out_ena
primed  out  1  high in RUN state
ovf_err  out  1  sticky: write attempted while full
udf_err  out  1  sticky: read attempted while empty
col_err  out  1  sticky: start pulse arrived during an active burst of the same kind

Behaviour:
- Reset (rst): every output is 0. State=IDLE. Both burst counters are idle.
- rst_user, sampled high:
  - Next cycle: state=IDLE, counters idle, all sticky flags cleared, fifo_sclr=1 for exactly one cycle.
  - wr_start and rd_start are ignored on the cycle rst_user is high.
- FSM states:
  - IDLE→PRIME on the first accepted wr_start.
  - PRIME→RUN on the cycle the write burst ends (last write), provided fifo_usedw≥N_UNITS-1 is sampled on that cycle (i.e. N_UNITS entries present after the write).
  - RUN is held until rst/rst_user.
- Write burst:
  - wr_start at cycle t → write window active t+1..t+N_UNITS; wr_idx counts 0..N_UNITS-1.
  - fifo_wrreq = window & ~fifo_full.
  - Window active while fifo_full → no write that cycle, ovf_err set; the index still advances.
  - Accepted in every state.
- Read burst:
  - rd_start at t, with primed high at t → read window active t+1..t+N_UNITS.
  - fifo_rdreq = window & ~fifo_empty. Window active while fifo_empty → no read, udf_err set.
  - rd_start while not primed: ignored, no error.
- Output timing:
  - out_ena = fifo_rdreq delayed 1 clk (the FIFO q is valid 1 cycle after rdreq).
  - out_idx = read index delayed 1 clk.
  - A suppressed read produces no out_ena pulse; the downstream register holds its last value.
- Collisions:
  - wr_start during an active write window: ignored, col_err set, burst continues. Same rule for rd_start during an active read window.
  - Same-cycle end of one burst and start pulse of that kind: the start is accepted (a back-to-back burst), with no gap cycle.
- Write and read windows are independent and may fully overlap. A simultaneous wrreq and rdreq is legal; fill level is unchanged.
- Index counters saturate-free: they return to 0 and deactivate after N_UNITS-1.

Decomposition:
- Shared package pwm_fifo_pkg: FSM state encoding (IDLE, PRIME, RUN), default N_UNITS and FIFO_DEPTH constants, IDX_W derivation function.
- Sub-module sched_burst_cnt, instantiated twice (write and read):
  - Inputs: start, clear.
  - Outputs: active, idx, last, collision.
  - Parameters: N_UNITS, IDX_W.

Test Plan:
- Reset release, then wr_start at cycle 5 → fifo_wrreq high cycles 6..15, wr_idx 0..9; primed=1 from cycle 16 (usedw model = 10).
- rd_start at cycle 2, before priming → no fifo_rdreq, udf_err=0. After priming, rd_start at 20 → fifo_rdreq 21..30, out_ena 22..31, out_idx 0..9.
- Overlapping wr_start and rd_start on the same cycle in RUN with usedw=10 → both windows run 10 cycles; fill level stays 10; no error flags.
- Force fifo_full=1 on cycle 3 of a write window → fifo_wrreq low that cycle, ovf_err=1 sticky, wr_idx still reaches 9. Force fifo_empty during a read window → udf_err=1, one missing out_ena pulse.
- wr_start repeated at window cycle 4 → col_err=1, burst length still 10. wr_start on the last window cycle → back-to-back burst of 20 writes, col_err unchanged.
- rst_user mid-read-burst at index 5 → fifo_sclr one cycle, fifo_rdreq low the next cycle, primed=0, all error flags 0; the subsequent rd_start is ignored until re-primed.
